// File: rtl/gfx_pkg.sv
// gfx_pkg: shared AXI response codes, bus widths and dispatcher state for the pixel writer.
package gfx_pkg;
  localparam int GFX_ADDR_W = 32;
  localparam int GFX_DATA_W = 32;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef enum logic {ST_IDLE, ST_ISSUE} disp_state_e;
endpackage

// File: rtl/gfx_pixel_fifo.sv
// gfx_pixel_fifo: synchronous FIFO with registered full/empty flags.
module gfx_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, empty_q;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign rdata = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  // full reads as set while in reset so the producer sees ready low until released
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= cnt_d == '0;
    end
  end
endmodule

// File: rtl/gfx_pixel_axi_writer.sv
// gfx_pixel_axi_writer: queues pixel writes and issues them as single-beat AXI writes; GFX_PIXEL_DEDUP_EN drops repeated beats.
module gfx_pixel_axi_writer
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [GFX_ADDR_W-1:0] pix_addr,
  input  logic [GFX_DATA_W-1:0] pix_data,
  output logic [GFX_ADDR_W-1:0] m00_axi_awaddr,
  output logic [2:0]            m00_axi_awprot,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  output logic [GFX_DATA_W-1:0] m00_axi_wdata,
  output logic [3:0]            m00_axi_wstrb,
  output logic                  m00_axi_wvalid,
  input  logic                  m00_axi_wready,
  input  logic [1:0]            m00_axi_bresp,
  input  logic                  m00_axi_bvalid,
  output logic                  m00_axi_bready,
  input  logic                  err_clear,
  output logic                  m00_axi_error,
  output logic                  busy
);
  logic accept, push, dispatch, fifo_full, fifo_empty;
  logic [GFX_ADDR_W+GFX_DATA_W-1:0] fifo_rdata;
  disp_state_e state_q;
  logic awvalid_q, wvalid_q, err_q;
  logic [GFX_ADDR_W-1:0] awaddr_q;
  logic [GFX_DATA_W-1:0] wdata_q;
  logic [3:0] outst_q;
  assign accept = pix_valid && pix_ready;
`ifdef GFX_PIXEL_DEDUP_EN
  logic prev_v_q;
  logic [GFX_ADDR_W+GFX_DATA_W-1:0] prev_q;
  always_ff @(posedge clk) begin
    if (reset || !pix_valid) prev_v_q <= 1'b0;
    else if (accept) begin
      prev_v_q <= 1'b1;
      prev_q   <= {pix_addr, pix_data};
    end
  end
  assign push = accept && !(prev_v_q && prev_q == {pix_addr, pix_data});
`else
  assign push = accept;
`endif
  gfx_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(GFX_ADDR_W + GFX_DATA_W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(dispatch),
    .wdata({pix_addr, pix_data}), .rdata(fifo_rdata),
    .full(fifo_full), .empty(fifo_empty)
  );
  assign pix_ready = !fifo_full;
  assign dispatch  = state_q == ST_IDLE && !fifo_empty && outst_q < 4'(MAX_OUTSTANDING);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      if (dispatch) begin
        state_q   <= ST_ISSUE;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= fifo_rdata[GFX_ADDR_W+GFX_DATA_W-1:GFX_DATA_W] & 32'hFFFF_FFFC;
        wdata_q   <= fifo_rdata[GFX_DATA_W-1:0];
      end
    end else begin
      awvalid_q <= awvalid_q && !m00_axi_awready;
      wvalid_q  <= wvalid_q && !m00_axi_wready;
      if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready)) state_q <= ST_IDLE;
    end
  end
  // a response arriving with nothing outstanding is ignored so the count never wraps
  always_ff @(posedge clk) begin
    if (reset) outst_q <= '0;
    else if (dispatch && !m00_axi_bvalid) outst_q <= outst_q + 4'd1;
    else if (!dispatch && m00_axi_bvalid && outst_q != '0) outst_q <= outst_q - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (m00_axi_bvalid && (m00_axi_bresp == AXI_RESP_SLVERR || m00_axi_bresp == AXI_RESP_DECERR)) err_q <= 1'b1;
    else if (err_clear) err_q <= 1'b0;
  end
  assign m00_axi_awaddr  = awaddr_q;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = awvalid_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_wstrb   = 4'hF;
  assign m00_axi_wvalid  = wvalid_q;
  assign m00_axi_bready  = 1'b1;
  assign m00_axi_error   = err_q;
  assign busy            = !fifo_empty || state_q == ST_ISSUE || outst_q != '0;
endmodule

// File: tb/tb_gfx_pixel_axi_writer.sv
// tb_gfx_pixel_axi_writer: randomized scoreboard bench for the pixel AXI writer.
module tb_gfx_pixel_axi_writer;
  localparam int MAXO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic pix_valid, pix_ready;
  logic [31:0] pix_addr, pix_data, awaddr, wdata;
  logic [2:0] awprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, err_clear, m_err, busy;
  logic [1:0] bresp;
  always #5 clk = ~clk;

  gfx_pixel_axi_writer #(.FIFO_DEPTH(16), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .err_clear(err_clear), .m00_axi_error(m_err), .busy(busy)
  );

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit aw_hold = 0, rnd = 0, b_en = 1, b_rand = 0, clr_on_serr = 0, man_clr = 0;
  int aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0, b_issued = 0;
  bit serr [int];
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, disp_cnt = 0, acc_cnt = 0;
  int last_acc_cyc = 0, last_rise_cyc = 0;
  logic [31:0] exp_aw [$];
  logic [31:0] exp_w [$];

  // AXI slave: configurable ready delays, responses only for completed AW+W pairs
  initial begin
    awready = 1; wready = 1; bvalid = 0; bresp = 0; err_clear = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        b_issued = 0; bvalid = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (bvalid) b_issued++;
        aw_wait = awvalid ? aw_wait + 1 : 0;
        w_wait  = wvalid ? w_wait + 1 : 0;
        bvalid = b_en && ((aw_cnt < w_cnt ? aw_cnt : w_cnt) > b_issued) && (!b_rand || $urandom_range(1) == 0);
      end
      awready = rnd ? 1'($urandom_range(1)) : (!aw_hold && aw_wait >= aw_dly);
      wready  = rnd ? 1'($urandom_range(1)) : (w_wait >= w_dly);
      bresp = (bvalid && serr.exists(b_issued)) ? 2'b10 : 2'b00;
      err_clear = man_clr || (clr_on_serr && bvalid && bresp[1]);
    end
  end

  // monitor: reference model of acceptance/dedup/error plus AXI scoreboard
  logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, exp_err = 0, prev_v = 0;
  logic [31:0] prev_awaddr = 0, prev_wdata = 0;
  logic [63:0] prev_beat = 0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_aw.delete(); exp_w.delete();
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; disp_cnt = 0;
      prev_awv = 0; prev_wv = 0; prev_v = 0; exp_err = 0;
    end else begin
      if (prev_awv && !prev_awr) chk("aw_stable", {awvalid, awaddr}, {1'b1, prev_awaddr});
      if (prev_awv && prev_awr) chk("aw_drop", awvalid, 0);
      if (prev_wv && !prev_wr) chk("w_stable", {wvalid, wdata}, {1'b1, prev_wdata});
      if (prev_wv && prev_wr) chk("w_drop", wvalid, 0);
      if (awvalid && !prev_awv) begin disp_cnt++; last_rise_cyc = cyc; end
      chk("outstanding_cap", (disp_cnt - b_cnt) <= MAXO, 1);
      chk("error_flag", m_err, exp_err);
      chk("static_outs", {bready, awprot, wstrb}, {1'b1, 3'b000, 4'hF});
      if (awvalid && awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 64'hDEAD);
        else chk("awaddr", awaddr, exp_aw.pop_front());
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (exp_w.size() == 0) chk("w_unexpected", wdata, 64'hDEAD);
        else chk("wdata", wdata, exp_w.pop_front());
      end
      if (bvalid) b_cnt++;
      exp_err = (bvalid && bresp[1]) ? 1'b1 : err_clear ? 1'b0 : exp_err;
      if (pix_valid && pix_ready) begin
        bit dup;
        acc_cnt++;
        last_acc_cyc = cyc;
`ifdef GFX_PIXEL_DEDUP_EN
        dup = prev_v && prev_beat == {pix_addr, pix_data};
`else
        dup = 0;
`endif
        if (!dup) begin
          exp_aw.push_back({pix_addr[31:2], 2'b00});
          exp_w.push_back(pix_data);
        end
        prev_beat = {pix_addr, pix_data};
        prev_v = 1;
      end else if (!pix_valid) prev_v = 0;
      prev_awv = awvalid; prev_awr = awready; prev_awaddr = awaddr;
      prev_wv = wvalid; prev_wr = wready; prev_wdata = wdata;
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    pix_addr = a; pix_data = d; pix_valid = 1;
    do begin @(negedge clk); n++; end while (!pix_ready && n < 500);
    chk("send_ready", pix_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || exp_aw.size() != 0 || exp_w.size() != 0) && n < 3000);
    chk("quiet", {busy, exp_aw.size() != 0, exp_w.size() != 0}, 0);
  endtask

  int base_acc, base_aw, base_w, base_d, base_b;
  logic [31:0] ra, rd;
  initial begin
    pix_valid = 0; pix_addr = 0; pix_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_valids", {awvalid, wvalid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", m_err, 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); @(negedge clk);
    chk("pix_ready_after_rst", pix_ready, 1);
    chk("rst_addr_data", {awaddr, wdata}, 0);
    // single beat, minimum latency
    sync();
    send(32'h1000_0004, 32'h00FF_00FF);
    pix_valid = 0;
    wait_quiet();
    chk("latency", last_rise_cyc - last_acc_cyc, 2);
    // FIFO fill with AW stalled
    sync();
    base_acc = acc_cnt; base_aw = aw_cnt; aw_hold = 1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(32'h2000_0000 + 32'(i) * 4, $urandom);
        pix_valid = 0;
      end
    join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("fill_count", acc_cnt - base_acc, 17);
    chk("fill_ready", pix_ready, 0);
    aw_hold = 0;
    wait fork;
    wait_quiet();
    chk("fill_writes", aw_cnt - base_aw, 20);
    // independent valid drops
    base_aw = aw_cnt; base_w = w_cnt;
    aw_dly = 2; w_dly = 0;
    sync();
    for (int i = 0; i < 3; i++) send(32'h4000_0000 + 32'(i) * 8, $urandom);
    pix_valid = 0;
    wait_quiet();
    aw_dly = 0; w_dly = 2;
    sync();
    for (int i = 0; i < 3; i++) send(32'h4100_0000 + 32'(i) * 8, $urandom);
    pix_valid = 0;
    wait_quiet();
    w_dly = 0;
    chk("indep_aw", aw_cnt - base_aw, 6);
    chk("indep_w", w_cnt - base_w, 6);
    // outstanding limit and SLVERR
    b_en = 0; base_d = disp_cnt; base_b = b_cnt;
    sync();
    for (int i = 0; i < 6; i++) send(32'h5000_0000 + 32'(i) * 4, $urandom);
    pix_valid = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("outst_limit", disp_cnt - base_d, 4);
    serr[b_issued + 2] = 1;
    b_en = 1;
    for (int n = 0; n < 100 && disp_cnt - base_d < 5; n++) @(negedge clk);
    chk("fifth_dispatch", disp_cnt - base_d, 5);
    chk("fifth_after_b", (b_cnt - base_b) >= 1, 1);
    wait_quiet();
    chk("slverr_set", m_err, 1);
    clr_on_serr = 1;
    serr[b_issued] = 1;
    sync();
    send(32'h5100_0000, 32'h1234_5678);
    pix_valid = 0;
    wait_quiet();
    chk("clr_collide", m_err, 1);
    clr_on_serr = 0;
    man_clr = 1;
    @(negedge clk);
    man_clr = 0;
    @(negedge clk);
    @(negedge clk);
    chk("err_cleared", m_err, 0);
    // randomized traffic
    rnd = 1; b_rand = 1;
    ra = $urandom; rd = $urandom;
    sync();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) begin pix_valid = 0; sync(); end
      if ($urandom_range(2) != 0) ra = $urandom;
      if ($urandom_range(2) != 0) rd = $urandom;
      send(ra, rd);
    end
    pix_valid = 0;
    wait_quiet();
    rnd = 0; b_rand = 0;
    // identical beat held for three cycles
    base_aw = aw_cnt;
    sync();
    pix_addr = 32'h3000_0010; pix_data = 32'hCAFE_BABE; pix_valid = 1;
    repeat (3) @(posedge clk);
    #1 pix_valid = 0;
    wait_quiet();
`ifdef GFX_PIXEL_DEDUP_EN
    chk("hold_writes", aw_cnt - base_aw, 1);
`else
    chk("hold_writes", aw_cnt - base_aw, 3);
`endif
    // reset with entries queued
    aw_hold = 1;
    sync();
    for (int i = 0; i < 5; i++) send(32'h6000_0000 + 32'(i) * 4, $urandom);
    pix_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1; aw_hold = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {awvalid, wvalid, busy}, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
